// File: rtl/pc_gen.sv
// Registered fetch-stage program counter with BOOT/RUN/HALT control, branch/jump redirect and a
// saturating redirect counter. Define PC_GEN_RAS_EN to add the return-address stack checker.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h3000),
  parameter logic [ADDR_W-1:0] TEXT_BASE = ADDR_W'(32'h3000),
  parameter int                CNT_W     = 16,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic              j_valid,
  input  logic              j_reg,
  input  logic              j_link,
  input  logic              j_ret,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [15:0]       offset,
  input  logic [25:0]       imm26,
  input  logic              zero,
  input  logic [ADDR_W-1:0] busA,
  input  logic              halt_req,
  input  logic              resume,
  output logic              flush,
  output logic [CNT_W-1:0]  redir_cnt,
  output logic              ras_hit,
  output logic              ras_miss
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BGTZ = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_flush;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_active;
  logic              w_br_taken;
  logic              w_redir;
  logic              w_busa_neg;
  logic              w_busa_zero;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [31:0]       w_j_raw;
  logic [ADDR_W-1:0] w_j_idx;
  logic [ADDR_W-1:0] w_j_tgt;
  logic [ADDR_W-1:0] w_tgt;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  if (halt_req) w_state_nxt = ST_HALT;
      ST_HALT: if (resume && !halt_req) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  assign w_active = (r_state != ST_BOOT);

  // ---------------------------------------------------------------------------
  // Branch condition and redirect targets
  // ---------------------------------------------------------------------------
  assign w_busa_neg  = busA[ADDR_W-1];
  assign w_busa_zero = (busA == '0);

  always_comb begin
    w_br_taken = 1'b0;
    case (br_type)
      BR_BEQ:  w_br_taken = zero;
      BR_BNE:  w_br_taken = !zero;
      BR_BGTZ: w_br_taken = !w_busa_neg && !w_busa_zero;
      BR_BLEZ: w_br_taken = w_busa_neg || w_busa_zero;
      BR_BLTZ: w_br_taken = w_busa_neg;
      BR_BGEZ: w_br_taken = !w_busa_neg;
      default: w_br_taken = 1'b0;
    endcase
  end

  assign w_br_off = {{(ADDR_W-18){offset[15]}}, offset, 2'b00};
  assign w_br_tgt = ex_pc + w_br_off;

  // The region bits come from the top of the resolving pc, as in the classic J encoding.
  assign w_j_raw = {ex_pc[ADDR_W-1 -: 4], imm26, 2'b00};
  assign w_j_idx = ADDR_W'(w_j_raw);
  assign w_j_tgt = TEXT_BASE + (j_reg ? busA : w_j_idx);

  // A jump masks a simultaneous branch; nothing redirects while still in BOOT.
  assign w_redir = w_active && (j_valid || (br_valid && w_br_taken));
  assign w_tgt   = j_valid ? w_j_tgt : w_br_tgt;

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_redir) begin
      w_pc_nxt = w_tgt;
    end else if ((r_state == ST_RUN) && if_ready) begin
      w_pc_nxt = r_pc + ADDR_W'(4);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VEC;
      r_flush <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_redir;
      if (w_redir && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign pc        = r_pc;
  assign if_valid  = (r_state == ST_RUN);
  assign flush     = r_flush;
  assign redir_cnt = r_cnt;

  // ---------------------------------------------------------------------------
  // Return-address stack
  // ---------------------------------------------------------------------------
`ifdef PC_GEN_RAS_EN
  localparam int                PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0]    RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ras_wp;
  logic [PTR_W:0]    r_ras_cnt;
  logic              r_ras_hit;
  logic              r_ras_miss;

  logic              w_push;
  logic              w_pop;
  logic              w_ras_empty;
  logic [PTR_W-1:0]  w_ras_top_idx;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_match;

  assign w_push        = w_active && j_valid && !j_reg && j_link;
  assign w_pop         = w_active && j_valid && j_reg && j_ret;
  assign w_ras_empty   = (r_ras_cnt == '0);
  assign w_ras_top_idx = r_ras_wp - PTR_W'(1);
  assign w_ras_top     = r_ras[w_ras_top_idx];
  assign w_ras_match   = !w_ras_empty && (w_ras_top == w_j_tgt);

  // The write pointer wraps, so a push into a full stack lands on the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ras_wp   <= '0;
      r_ras_cnt  <= '0;
      r_ras_hit  <= 1'b0;
      r_ras_miss <= 1'b0;
    end else begin
      r_ras_hit  <= w_pop && w_ras_match;
      r_ras_miss <= w_pop && !w_ras_match;
      if (w_push) begin
        r_ras_wp <= r_ras_wp + PTR_W'(1);
        if (r_ras_cnt != RAS_FULL) begin
          r_ras_cnt <= r_ras_cnt + (PTR_W+1)'(1);
        end
      end else if (w_pop && !w_ras_empty) begin
        r_ras_wp  <= w_ras_top_idx;
        r_ras_cnt <= r_ras_cnt - (PTR_W+1)'(1);
      end
    end
  end

  // NOTE: stack storage is left unreset; r_ras_cnt guarantees no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_ras_wp] <= ex_pc + ADDR_W'(4);
    end
  end

  assign ras_hit  = r_ras_hit;
  assign ras_miss = r_ras_miss;
`else
  logic w_unused_ras;
  assign w_unused_ras = ^{j_link, j_ret};

  assign ras_hit  = 1'b0;
  assign ras_miss = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected cycle results are queued when stimulus is driven and
// compared one cycle later. The RAS expectations follow PC_GEN_RAS_EN.
module tb_pc_gen;

  localparam int               CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_ready;
  logic              if_valid;
  logic [31:0]       pc;
  logic              br_valid;
  logic [2:0]        br_type;
  logic              j_valid;
  logic              j_reg;
  logic              j_link;
  logic              j_ret;
  logic [31:0]       ex_pc;
  logic [15:0]       offset;
  logic [25:0]       imm26;
  logic              zero;
  logic [31:0]       busA;
  logic              halt_req;
  logic              resume;
  logic              flush;
  logic [CNT_W-1:0]  redir_cnt;
  logic              ras_hit;
  logic              ras_miss;

  pc_gen #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_ready (if_ready),
    .if_valid (if_valid),
    .pc       (pc),
    .br_valid (br_valid),
    .br_type  (br_type),
    .j_valid  (j_valid),
    .j_reg    (j_reg),
    .j_link   (j_link),
    .j_ret    (j_ret),
    .ex_pc    (ex_pc),
    .offset   (offset),
    .imm26    (imm26),
    .zero     (zero),
    .busA     (busA),
    .halt_req (halt_req),
    .resume   (resume),
    .flush    (flush),
    .redir_cnt(redir_cnt),
    .ras_hit  (ras_hit),
    .ras_miss (ras_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [31:0]      pc;
    logic             v;
    logic             fl;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic             miss;
  } exp_t;

  exp_t             sb_q[$];
  int               total = 0;
  int               bad   = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [31:0]      exp_pc;
  bit   [2:0]       tk_tab [8];
  int               br_list [6];
  logic [31:0]      busa_list [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    if_ready = 1'b1;
    br_valid = 1'b0;
    br_type  = 3'd0;
    j_valid  = 1'b0;
    j_reg    = 1'b0;
    j_link   = 1'b0;
    j_ret    = 1'b0;
    ex_pc    = '0;
    offset   = '0;
    imm26    = '0;
    zero     = 1'b0;
    busA     = '0;
    halt_req = 1'b0;
    resume   = 1'b0;
  endtask

  task automatic bump();
    exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1'b1;
  endtask

  // Queue the expected post-edge outputs, clock once, then pop and compare.
  task automatic step(input string tag, input logic [31:0] e_pc, input logic e_v,
                      input logic e_fl, input logic e_hit, input logic e_miss);
    exp_t e;
    e.tag  = tag;
    e.pc   = e_pc;
    e.v    = e_v;
    e.fl   = e_fl;
    e.cnt  = exp_cnt;
    e.hit  = e_hit;
    e.miss = e_miss;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".pc"},    pc,                32'(e.pc));
    check({e.tag, ".valid"}, 32'(if_valid),     32'(e.v));
    check({e.tag, ".flush"}, 32'(flush),        32'(e.fl));
    check({e.tag, ".cnt"},   32'(redir_cnt),    32'(e.cnt));
    check({e.tag, ".hit"},   32'(ras_hit),      32'(e.hit));
    check({e.tag, ".miss"},  32'(ras_miss),     32'(e.miss));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc"},    pc,             32'h0000_3000);
    check({tag, ".valid"}, 32'(if_valid),  32'd0);
    check({tag, ".flush"}, 32'(flush),     32'd0);
    check({tag, ".cnt"},   32'(redir_cnt), 32'd0);
    check({tag, ".hit"},   32'(ras_hit),   32'd0);
    check({tag, ".miss"},  32'(ras_miss),  32'd0);
  endtask

  initial begin
    logic tk;
    logic [31:0] tgt;

    rst_n = 1'b0;
    idle_inputs();
    exp_cnt = '0;
    // Hand-derived taken bits: bit k belongs to busA = 0, 1, 0x80000000; BNE runs with zero=0.
    tk_tab[1] = 3'b111;
    tk_tab[2] = 3'b010;
    tk_tab[3] = 3'b101;
    tk_tab[4] = 3'b100;
    tk_tab[5] = 3'b011;
    tk_tab[7] = 3'b000;
    br_list   = '{1, 2, 3, 4, 5, 7};
    busa_list = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000};

    #12;
    check_reset("reset");
    rst_n = 1'b1;

    // A jump offered during BOOT must be ignored.
    j_valid = 1'b1;
    j_reg   = 1'b1;
    busA    = 32'h500;
    step("boot", 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_inputs();

    step("seq1", 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);
    step("seq2", 32'h3008, 1'b1, 1'b0, 1'b0, 1'b0);
    step("seq3", 32'h300c, 1'b1, 1'b0, 1'b0, 1'b0);
    step("seq4", 32'h3010, 1'b1, 1'b0, 1'b0, 1'b0);

    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("stall", 32'h3010, 1'b1, 1'b0, 1'b0, 1'b0);
    if_ready = 1'b1;
    step("unstall", 32'h3014, 1'b1, 1'b0, 1'b0, 1'b0);

    // BEQ taken with negative offset, then the same branch not taken.
    br_valid = 1'b1; br_type = 3'd0; zero = 1'b1; ex_pc = 32'h3020; offset = 16'hFFFE;
    bump();
    step("beq_t", 32'h3018, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    step("beq_after", 32'h301c, 1'b1, 1'b0, 1'b0, 1'b0);
    br_valid = 1'b1; br_type = 3'd0; zero = 1'b0; ex_pc = 32'h3020; offset = 16'hFFFE;
    step("beq_nt", 32'h3020, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_pc = 32'h3020;

    // Signed branch conditions across busA = 0, 1, most-negative.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 3; k++) begin
        br_valid = 1'b1; br_type = 3'(br_list[t]); zero = 1'b0;
        ex_pc = 32'h3100; offset = 16'h0010; busA = busa_list[k];
        tk = tk_tab[br_list[t]][k];
        if (tk) begin
          bump();
          exp_pc = 32'h3140;
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
        step($sformatf("br%0d_a%0d", br_list[t], k), exp_pc, 1'b1, tk, 1'b0, 1'b0);
      end
    end
    idle_inputs();

    j_valid = 1'b1; j_reg = 1'b1; busA = 32'h40;
    bump();
    step("jr", 32'h3040, 1'b1, 1'b1, 1'b0, 1'b0);

    // Jump and taken branch together: the jump target wins.
    idle_inputs();
    j_valid = 1'b1; ex_pc = 32'h3200; imm26 = 26'h100;
    br_valid = 1'b1; br_type = 3'd0; zero = 1'b1; offset = 16'h0004;
    bump();
    step("j_vs_br", 32'h3400, 1'b1, 1'b1, 1'b0, 1'b0);

    // Redirect while the consumer stalls.
    idle_inputs();
    if_ready = 1'b0;
    br_valid = 1'b1; br_type = 3'd0; zero = 1'b1; ex_pc = 32'h3400; offset = 16'h0008;
    bump();
    step("stall_br", 32'h3420, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    if_ready = 1'b0;
    step("stall_hold", 32'h3420, 1'b1, 1'b0, 1'b0, 1'b0);
    if_ready = 1'b1;
    step("stall_go", 32'h3424, 1'b1, 1'b0, 1'b0, 1'b0);

    // Halt: the entering cycle is still RUN, so the pc advances once more.
    halt_req = 1'b1;
    step("halt_enter", 32'h3428, 1'b0, 1'b0, 1'b0, 1'b0);
    halt_req = 1'b0;
    step("halt_hold1", 32'h3428, 1'b0, 1'b0, 1'b0, 1'b0);
    step("halt_hold2", 32'h3428, 1'b0, 1'b0, 1'b0, 1'b0);
    j_valid = 1'b1; j_reg = 1'b1; busA = 32'h80;
    bump();
    step("halt_jr", 32'h3080, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    halt_req = 1'b1; resume = 1'b1;
    step("halt_both", 32'h3080, 1'b0, 1'b0, 1'b0, 1'b0);
    halt_req = 1'b0;
    step("resume", 32'h3080, 1'b1, 1'b0, 1'b0, 1'b0);
    resume = 1'b0;
    step("run_again", 32'h3084, 1'b1, 1'b0, 1'b0, 1'b0);

    // Five calls then six returns; a 4-entry stack loses the oldest call.
    for (int k = 1; k <= 5; k++) begin
      idle_inputs();
      j_valid = 1'b1; j_link = 1'b1;
      ex_pc = 32'h3000 + 32'h100 * k; imm26 = 26'(32'h200 + k);
      tgt = 32'h3800 + 32'd4 * k;
      bump();
      step($sformatf("jal%0d", k), tgt, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    for (int k = 5; k >= 0; k--) begin
      idle_inputs();
      j_valid = 1'b1; j_reg = 1'b1; j_ret = 1'b1; ex_pc = 32'h3900;
      busA = 32'h100 * k + 32'd4;
      tgt = 32'h3000 + busA;
      bump();
      step($sformatf("ret%0d", k), tgt, 1'b1, 1'b1,
           RAS_ON && (k >= 2), RAS_ON && (k < 2));
    end

    // The count is saturated by now; further redirects must not wrap it.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      j_valid = 1'b1; j_reg = 1'b1; busA = 32'h10;
      bump();
      step($sformatf("sat%0d", i), 32'h3010, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    idle_inputs();

    // Asynchronous reset mid-operation, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    rst_n = 1'b1;
    exp_cnt = '0;
    step("reboot", 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
    step("reboot_seq", 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
